// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared encodings and defaults for the VGA pattern source
//
// Purpose: pattern encodings, colour channel width and default raster size,
//          imported by the interface, the pixel counter and the top.
// Ports:   none (package).
// Config:  none here; the top honours `VGA_PATTERN_BORDER_EN.
package vga_pkg;

    localparam int COLOR_W        = 4;
    localparam int DEF_H_PIXELS   = 640;
    localparam int DEF_V_LINES    = 480;
    localparam int DEF_CHECK_LOG2 = 5;

    typedef enum logic [1:0] {
        PAT_WHITE = 2'd0,
        PAT_BARS  = 2'd1,
        PAT_CHECK = 2'd2,
        PAT_GRAD  = 2'd3
    } pattern_e;

endpackage

// File: rtl/vga_pattern_gen_if.sv
// rtl/vga_pattern_gen_if.sv - timing-in / pixel-out bundle of the pattern source
//
// Purpose: groups the vga_timing strobes, the pattern request and the
//          RGB + delayed sync outputs into one interface.
// Ports (signals):
//   h_sync_in, v_sync_in, h_active_in, v_active_in, active_in  timing strobes in
//   pattern_sel[1:0]                                           pattern request in
//   r, g, b [COLOR_W-1:0]                                      pixel colour out
//   h_sync, v_sync                                             syncs delayed 2 cycles
//   frame_tick                                                 output-aligned frame start
// Modports: master (timing source / sink side), slave (pattern generator).
interface vga_pattern_gen_if;
    import vga_pkg::*;

    logic               h_sync_in;
    logic               v_sync_in;
    logic               h_active_in;
    logic               v_active_in;
    logic               active_in;
    logic [1:0]         pattern_sel;
    logic [COLOR_W-1:0] r;
    logic [COLOR_W-1:0] g;
    logic [COLOR_W-1:0] b;
    logic               h_sync;
    logic               v_sync;
    logic               frame_tick;

    modport master (
        output h_sync_in, v_sync_in, h_active_in, v_active_in, active_in, pattern_sel,
        input  r, g, b, h_sync, v_sync, frame_tick
    );

    modport slave (
        input  h_sync_in, v_sync_in, h_active_in, v_active_in, active_in, pattern_sel,
        output r, g, b, h_sync, v_sync, frame_tick
    );

endinterface

// File: rtl/vga_pixel_counter.sv
// rtl/vga_pixel_counter.sv - pixel x/y, bar index, frame start, synced flag, frame count
//
// Purpose: recovers the coordinate of the pixel currently on the timing
//          inputs and exposes the per-pixel attributes the colour stage needs.
// Ports:
//   clk, reset                     pixel clock, synchronous active-high reset
//   h_active_i, v_active_i, active_i  timing strobes
//   pattern_sel_i                  pattern request, latched at frame start
//   frame_start_o                  rising edge of v_active_i this cycle
//   pattern_o, synced_o            latched pattern, first frame start seen
//   frame_phase_o                  frame_cnt[5:2] for the gradient scroll
//   bar_idx_o                      colour bar index of the current pixel
//   check_o                        checkerboard bit x[C]^y[C] of the current pixel
//   grad_x_o, grad_y_o             x[6:3], y[6:3] of the current pixel
//   edge_o                         pixel on the raster border (VGA_PATTERN_BORDER_EN only)
module vga_pixel_counter
    import vga_pkg::*;
#(
    parameter int H_PIXELS   = DEF_H_PIXELS,
    parameter int V_LINES    = DEF_V_LINES,
    parameter int CHECK_LOG2 = DEF_CHECK_LOG2
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     h_active_i,
    input  logic     v_active_i,
    input  logic     active_i,
    input  logic [1:0] pattern_sel_i,
`ifdef VGA_PATTERN_BORDER_EN
    output logic     edge_o,
`endif
    output logic     frame_start_o,
    output pattern_e pattern_o,
    output logic     synced_o,
    output logic [3:0] frame_phase_o,
    output logic [2:0] bar_idx_o,
    output logic     check_o,
    output logic [3:0] grad_x_o,
    output logic [3:0] grad_y_o
);

    // At least 7 bits so the gradient can always pick bits [6:3].
    localparam int XW      = ($clog2(H_PIXELS) > 7) ? $clog2(H_PIXELS) : 7;
    localparam int YW      = ($clog2(V_LINES)  > 7) ? $clog2(V_LINES)  : 7;
    localparam int BAR_LEN = H_PIXELS / 8;
    localparam int SW      = (BAR_LEN > 1) ? $clog2(BAR_LEN) : 1;

    // x_q/y_q/bar_q hold the coordinate of the pixel presented this cycle.
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [SW-1:0] sub_q, sub_d;
    logic [2:0]    bar_q, bar_d;
    logic [7:0]    cnt_q, cnt_d;
    pattern_e      pat_q, pat_d;
    logic          synced_q, synced_d;
    logic          h_prev_q;
    logic          v_prev_q;
    logic          frame_start;

    // v_prev resets high so a release in mid-frame cannot fake a rising edge.
    assign frame_start = v_active_i & ~v_prev_q;

    always_comb begin
        x_d      = x_q;
        y_d      = y_q;
        sub_d    = sub_q;
        bar_d    = bar_q;
        cnt_d    = cnt_q;
        pat_d    = pat_q;
        synced_d = synced_q;

        if (!h_active_i) begin
            x_d   = '0;
            sub_d = '0;
            bar_d = '0;
        end else if (active_i) begin
            if (x_q != XW'(H_PIXELS - 1)) begin
                x_d = x_q + XW'(1);
            end
            if (sub_q == SW'(BAR_LEN - 1)) begin
                sub_d = '0;
                if (bar_q != 3'd7) begin
                    bar_d = bar_q + 3'd1;
                end
            end else begin
                sub_d = sub_q + SW'(1);
            end
        end

        if (!v_active_i) begin
            y_d = '0;
        end else if (h_prev_q && !h_active_i && (y_q != YW'(V_LINES - 1))) begin
            y_d = y_q + YW'(1);
        end

        if (frame_start) begin
            pat_d    = pattern_e'(pattern_sel_i);
            cnt_d    = cnt_q + 8'd1;
            synced_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x_q      <= '0;
            y_q      <= '0;
            sub_q    <= '0;
            bar_q    <= '0;
            cnt_q    <= '0;
            pat_q    <= PAT_WHITE;
            synced_q <= 1'b0;
            h_prev_q <= 1'b0;
            v_prev_q <= 1'b1;
        end else begin
            x_q      <= x_d;
            y_q      <= y_d;
            sub_q    <= sub_d;
            bar_q    <= bar_d;
            cnt_q    <= cnt_d;
            pat_q    <= pat_d;
            synced_q <= synced_d;
            h_prev_q <= h_active_i;
            v_prev_q <= v_active_i;
        end
    end

    assign frame_start_o = frame_start;
    assign pattern_o     = pat_q;
    assign synced_o      = synced_q;
    assign frame_phase_o = cnt_q[5:2];
    assign bar_idx_o     = bar_q;
    assign check_o       = x_q[CHECK_LOG2] ^ y_q[CHECK_LOG2];
    assign grad_x_o      = x_q[6:3];
    assign grad_y_o      = y_q[6:3];
`ifdef VGA_PATTERN_BORDER_EN
    assign edge_o = (x_q == '0) || (x_q == XW'(H_PIXELS - 1)) ||
                    (y_q == '0) || (y_q == YW'(V_LINES - 1));
`endif

endmodule

// File: rtl/vga_pattern_gen.sv
// rtl/vga_pattern_gen.sv - 2-stage test pattern source behind vga_timing
//
// Purpose: stage 1 registers the pixel attributes and the timing strobes,
//          stage 2 registers the colour and the delayed syncs.
// Ports:
//   clk, reset   pixel clock, synchronous active-high reset
//   vif (slave)  timing strobes + pattern_sel in; r/g/b, h_sync, v_sync,
//                frame_tick out, all 2 cycles behind the inputs
// Config: `VGA_PATTERN_BORDER_EN paints a red 1-pixel frame border.
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int H_PIXELS   = DEF_H_PIXELS,
    parameter int V_LINES    = DEF_V_LINES,
    parameter int CHECK_LOG2 = DEF_CHECK_LOG2
) (
    input logic              clk,
    input logic              reset,
    vga_pattern_gen_if.slave vif
);

    localparam logic [COLOR_W-1:0] C_ON  = '1;
    localparam logic [COLOR_W-1:0] C_OFF = '0;

    logic       frame_start;
    pattern_e   pattern;
    logic       synced;
    logic [3:0] frame_phase;
    logic [2:0] bar_idx;
    logic       check;
    logic [3:0] grad_x;
    logic [3:0] grad_y;
`ifdef VGA_PATTERN_BORDER_EN
    logic       edge_px;
    logic       edge1_q;
`endif

    vga_pixel_counter #(
        .H_PIXELS   (H_PIXELS),
        .V_LINES    (V_LINES),
        .CHECK_LOG2 (CHECK_LOG2)
    ) u_counter (
        .clk           (clk),
        .reset         (reset),
        .h_active_i    (vif.h_active_in),
        .v_active_i    (vif.v_active_in),
        .active_i      (vif.active_in),
        .pattern_sel_i (vif.pattern_sel),
`ifdef VGA_PATTERN_BORDER_EN
        .edge_o        (edge_px),
`endif
        .frame_start_o (frame_start),
        .pattern_o     (pattern),
        .synced_o      (synced),
        .frame_phase_o (frame_phase),
        .bar_idx_o     (bar_idx),
        .check_o       (check),
        .grad_x_o      (grad_x),
        .grad_y_o      (grad_y)
    );

    // Stage 1: pixel attributes and strobes of the pixel sampled this edge.
    logic       hs1_q, vs1_q, act1_q, fs1_q, check1_q;
    logic [2:0] bar1_q;
    logic [3:0] gx1_q, gy1_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            hs1_q    <= 1'b0;
            vs1_q    <= 1'b0;
            act1_q   <= 1'b0;
            fs1_q    <= 1'b0;
            check1_q <= 1'b0;
            bar1_q   <= '0;
            gx1_q    <= '0;
            gy1_q    <= '0;
`ifdef VGA_PATTERN_BORDER_EN
            edge1_q  <= 1'b0;
`endif
        end else begin
            hs1_q    <= vif.h_sync_in;
            vs1_q    <= vif.v_sync_in;
            act1_q   <= vif.active_in;
            fs1_q    <= frame_start;
            check1_q <= check;
            bar1_q   <= bar_idx;
            gx1_q    <= grad_x;
            gy1_q    <= grad_y;
`ifdef VGA_PATTERN_BORDER_EN
            edge1_q  <= edge_px;
`endif
        end
    end

    // Stage 2: colour. pattern/frame_phase are read one edge after the
    // pixel was sampled, so a frame start on that pixel's cycle already
    // applies to it.
    logic [COLOR_W-1:0] r_d, g_d, b_d, grad_r;
    logic [COLOR_W-1:0] r_q, g_q, b_q;
    logic               hs_q, vs_q, tick_q;

    assign grad_r = gx1_q + frame_phase;

    always_comb begin
        r_d = C_OFF;
        g_d = C_OFF;
        b_d = C_OFF;
        if (act1_q && synced) begin
            case (pattern)
                PAT_WHITE: begin
                    r_d = C_ON;
                    g_d = C_ON;
                    b_d = C_ON;
                end
                PAT_BARS: begin
                    r_d = {COLOR_W{~bar1_q[1]}};
                    g_d = {COLOR_W{~bar1_q[2]}};
                    b_d = {COLOR_W{~bar1_q[0]}};
                end
                PAT_CHECK: begin
                    r_d = {COLOR_W{check1_q}};
                    g_d = {COLOR_W{check1_q}};
                    b_d = {COLOR_W{check1_q}};
                end
                PAT_GRAD: begin
                    r_d = grad_r;
                    g_d = gy1_q;
                    b_d = C_ON - grad_r;
                end
                default: begin
                    r_d = C_OFF;
                    g_d = C_OFF;
                    b_d = C_OFF;
                end
            endcase
`ifdef VGA_PATTERN_BORDER_EN
            if (edge1_q) begin
                r_d = C_ON;
                g_d = C_OFF;
                b_d = C_OFF;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q    <= '0;
            g_q    <= '0;
            b_q    <= '0;
            hs_q   <= 1'b0;
            vs_q   <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            r_q    <= r_d;
            g_q    <= g_d;
            b_q    <= b_d;
            hs_q   <= hs1_q;
            vs_q   <= vs1_q;
            tick_q <= fs1_q;
        end
    end

    assign vif.r          = r_q;
    assign vif.g          = g_q;
    assign vif.b          = b_q;
    assign vif.h_sync     = hs_q;
    assign vif.v_sync     = vs_q;
    assign vif.frame_tick = tick_q;

endmodule
